// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - power-of-two and DIV_N clock divider (optional macro: CLKDIV_ODD_DUTY50_EN)
module clock_divider #(
    parameter int unsigned DIV_N = 6
) (
    input  logic clk,
    input  logic rst,
    output logic clk2,
    output logic clk4,
    output logic clk8,
    output logic clkn
);

    // Modulo counter is 8 bits wide, enough for ratios up to 255.
    localparam logic [7:0] LAST    = 8'(DIV_N - 1);
    localparam logic [7:0] HALF_M1 = 8'(DIV_N / 2 - 1);
    localparam bit         ODD     = (DIV_N % 2) == 1;
`ifdef CLKDIV_ODD_DUTY50_EN
    // The falling-edge flop stretches the high phase by half a period,
    // so the rising-edge flop only stays high for (DIV_N-1)/2 cycles.
    localparam logic [7:0] ODD_FALL = 8'((DIV_N - 1) / 2);
`else
    // High for (DIV_N+1)/2 cycles, low for the remaining (DIV_N-1)/2.
    localparam logic [7:0] ODD_FALL = 8'((DIV_N + 1) / 2);
`endif

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] mod_q, mod_d;
    logic       clkn_q, clkn_d;

    // Next-state logic for the binary counter, modulo counter and clkn flop.
    always_comb begin
        cnt_d  = cnt_q + 3'd1;
        mod_d  = (mod_q == LAST) ? 8'd0 : mod_q + 8'd1;
        clkn_d = clkn_q;
        if (ODD) begin
            // Rise on the edge that leaves count 0 so the first edge after reset raises clkn.
            if (mod_q == 8'd0) begin
                clkn_d = 1'b1;
            end else if (mod_q == ODD_FALL) begin
                clkn_d = 1'b0;
            end
        end else begin
            if (mod_q == HALF_M1 || mod_q == LAST) begin
                clkn_d = ~clkn_q;
            end
        end
    end

    // Rising-edge state; reset clears everything without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 3'd0;
            mod_q  <= 8'd0;
            clkn_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mod_q  <= mod_d;
            clkn_q <= clkn_d;
        end
    end

    assign clk2 = cnt_q[0];
    assign clk4 = cnt_q[1];
    assign clk8 = cnt_q[2];

`ifdef CLKDIV_ODD_DUTY50_EN
    generate
        if (ODD) begin : g_odd50
            logic clkn_neg_q;

            // Half-period delayed copy of clkn_q; OR-ing both gives exactly 50% duty.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    clkn_neg_q <= 1'b0;
                end else begin
                    clkn_neg_q <= clkn_q;
                end
            end

            assign clkn = clkn_q | clkn_neg_q;
        end else begin : g_even
            assign clkn = clkn_q;
        end
    endgenerate
`else
    assign clkn = clkn_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - scoreboard bench for clock_divider at DIV_N = 6, 2 and 5
module tb_clock_divider;

    typedef struct packed {
        logic [2:0] cnt;
        logic       n6;
        logic       n2;
        logic       n5;
    } sample_t;

    typedef struct packed {
        sample_t a;
        sample_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic c2_6, c4_6, c8_6, cn_6;
    logic c2_2, c4_2, c8_2, cn_2;
    logic c2_5, c4_5, c8_5, cn_5;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t exp_q[$];

    // Expected values after rising edge k (index k-1) following reset release.
    localparam bit [2:0] CNT_TAB [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                                          3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    localparam bit N6_TAB  [16] = '{0,0,1,1,1,0,0,0,1,1,1,0,0,0,1,1};
    localparam bit N2_TAB  [16] = '{1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0};
    // DIV_N=5 sampled a quarter period after the rising edge.
    localparam bit N5A_TAB [16] = '{1,1,1,0,0,1,1,1,0,0,1,1,1,0,0,1};
`ifdef CLKDIV_ODD_DUTY50_EN
    // Three quarters after the edge the half-period extension has already ended.
    localparam bit N5B_TAB [16] = '{1,1,0,0,0,1,1,0,0,0,1,1,0,0,0,1};
`else
    localparam bit N5B_TAB [16] = '{1,1,1,0,0,1,1,1,0,0,1,1,1,0,0,1};
`endif

    clock_divider #(.DIV_N(6)) u_div6 (
        .clk (clk), .rst (rst), .clk2 (c2_6), .clk4 (c4_6), .clk8 (c8_6), .clkn (cn_6)
    );
    clock_divider #(.DIV_N(2)) u_div2 (
        .clk (clk), .rst (rst), .clk2 (c2_2), .clk4 (c4_2), .clk8 (c8_2), .clkn (cn_2)
    );
    clock_divider #(.DIV_N(5)) u_div5 (
        .clk (clk), .rst (rst), .clk2 (c2_5), .clk4 (c4_5), .clk8 (c8_5), .clkn (cn_5)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input string ph, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s cyc=%0d phase=%s got=%0d exp=%0d", name, cyc, ph, got, expv);
        end
    endtask

    task automatic compare(input sample_t e, input string ph);
        check("cnt_div6", ph, int'({c8_6, c4_6, c2_6}), int'(e.cnt));
        check("cnt_div2", ph, int'({c8_2, c4_2, c2_2}), int'(e.cnt));
        check("cnt_div5", ph, int'({c8_5, c4_5, c2_5}), int'(e.cnt));
        check("clkn_div6", ph, int'(cn_6), int'(e.n6));
        check("clkn_div2", ph, int'(cn_2), int'(e.n2));
        check("clkn_div5", ph, int'(cn_5), int'(e.n5));
    endtask

    function automatic sample_t tab_a(input int k);
        return '{cnt: CNT_TAB[k-1], n6: N6_TAB[k-1], n2: N2_TAB[k-1], n5: N5A_TAB[k-1]};
    endfunction

    function automatic sample_t tab_b(input int k);
        return '{cnt: CNT_TAB[k-1], n6: N6_TAB[k-1], n2: N2_TAB[k-1], n5: N5B_TAB[k-1]};
    endfunction

    // Monitor: samples a quarter and three quarters into every cycle with an expectation queued.
    initial begin
        forever begin
            @(posedge clk);
            #5;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q[0];
                compare(e.a, "A");
                #10;
                compare(e.b, "B");
                void'(exp_q.pop_front());
                cyc++;
            end
        end
    end

    // Stimulus: drives rst and queues the expected outputs for each cycle.
    initial begin
        sample_t zero;
        zero = '0;
        rst  = 1'b1;

        // Reset held from time 0 through 52 ns with clk running.
        repeat (3) begin
            @(posedge clk);
            exp_q.push_back({zero, zero});
        end
        #2 rst = 1'b0;

        // Five edges to reach count 5, then reset lands between the two samples.
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            if (k < 5) begin
                exp_q.push_back({tab_a(k), tab_b(k)});
            end else begin
                exp_q.push_back({tab_a(k), zero});
                #8 rst = 1'b1;
            end
        end

        repeat (2) begin
            @(posedge clk);
            exp_q.push_back({zero, zero});
        end
        #2 rst = 1'b0;

        // Restart must follow the same sequence from the first edge.
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            exp_q.push_back({tab_a(k), tab_b(k)});
        end

        repeat (2) @(posedge clk);
        #16;
        check("queue_drained", "end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
